// File: rtl/envelope_scaler_if.sv
// Bus between the envelope scaler and its driver: gate pulses, ADSR rates,
// the raw sample in, and the scaled sample plus envelope status out.
interface envelope_scaler_if #(
    parameter int WAVE_DEPTH = 8,
    parameter int ENV_DEPTH  = 8
);
    logic                  gate_open;
    logic                  gate_close;
    logic [7:0]            attack;
    logic [7:0]            decay;
    logic [ENV_DEPTH-1:0]  sustain;
    logic [7:0]            release_rate;
    logic [WAVE_DEPTH-1:0] waveform;
    logic [WAVE_DEPTH-1:0] out;
    logic [ENV_DEPTH-1:0]  level;
    logic [2:0]            state;
    logic                  active;

    modport master (
        output gate_open, gate_close, attack, decay, sustain, release_rate, waveform,
        input  out, level, state, active
    );

    modport slave (
        input  gate_open, gate_close, attack, decay, sustain, release_rate, waveform,
        output out, level, state, active
    );
endinterface

// File: rtl/envelope_scaler.sv
// ADSR envelope generator with a registered amplitude scaler on the output.
//
// state   | meaning
// IDLE    | envelope at rest, accumulator held
// ATTACK  | ramping up by attack+1 per cycle until full scale
// DECAY   | ramping down by decay+1 per cycle until sustain level
// SUSTAIN | accumulator follows the live sustain level
// RELEASE | ramping down by release+1 per cycle until zero
module envelope_scaler #(
    parameter int WAVE_DEPTH = 8,
    parameter int ENV_DEPTH  = 8,
    parameter int FRAC       = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    envelope_scaler_if.slave  bus
);
    localparam int ACC_W  = ENV_DEPTH + FRAC;
    localparam int PROD_W = WAVE_DEPTH + ENV_DEPTH;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [WAVE_DEPTH-1:0] out_q, out_d;

    // One extra bit on all comparisons so neither overflow nor underflow can wrap.
    logic [ACC_W:0] acc_w, inc_w, dec_w, rel_w, sus_w, max_w, sum_w, floor_w;
    logic [ENV_DEPTH-1:0] level_w;
    logic [PROD_W-1:0]    prod_w;

    assign acc_w   = {1'b0, acc_q};
    assign inc_w   = (ACC_W+1)'(bus.attack) + (ACC_W+1)'(1);
    assign dec_w   = (ACC_W+1)'(bus.decay) + (ACC_W+1)'(1);
    assign rel_w   = (ACC_W+1)'(bus.release_rate) + (ACC_W+1)'(1);
    assign sus_w   = {1'b0, bus.sustain, {FRAC{1'b0}}};
    assign max_w   = {1'b0, {ACC_W{1'b1}}};
    assign sum_w   = acc_w + inc_w;
    assign floor_w = sus_w + dec_w;

    assign level_w = acc_q[ACC_W-1:FRAC];
    assign prod_w  = PROD_W'(bus.waveform) * PROD_W'(level_w);
    assign out_d   = prod_w[PROD_W-1:ENV_DEPTH];

    // Next envelope state and accumulator value; gate pulses override the phase step.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        case (state_q)
            ATTACK: begin
                if (sum_w >= max_w) begin
                    acc_d   = '1;
                    state_d = DECAY;
                end else begin
                    acc_d = sum_w[ACC_W-1:0];
                end
            end
            DECAY: begin
                if (sus_w >= acc_w || acc_w <= floor_w) begin
                    acc_d   = sus_w[ACC_W-1:0];
                    state_d = SUSTAIN;
                end else begin
                    acc_d = acc_q - dec_w[ACC_W-1:0];
                end
            end
            SUSTAIN: acc_d = sus_w[ACC_W-1:0];
            RELEASE: begin
                if (acc_w <= rel_w) begin
                    acc_d   = '0;
                    state_d = IDLE;
                end else begin
                    acc_d = acc_q - rel_w[ACC_W-1:0];
                end
            end
            default: acc_d = acc_q;
        endcase

        // A held gate keeps stepping the attack so it behaves like a continuous attack.
        if (bus.gate_open) begin
            state_d = ATTACK;
            if (state_q != ATTACK) begin
                acc_d = acc_q;
            end
        end else if (bus.gate_close &&
                     (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN)) begin
            state_d = RELEASE;
            acc_d   = acc_q;
        end
    end

    // Envelope state, accumulator and scaled output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
        end
    end

    assign bus.out    = out_q;
    assign bus.level  = level_w;
    assign bus.state  = state_q;
    assign bus.active = (state_q != IDLE);
endmodule

// File: tb/tb_envelope_scaler.sv
// Directed bench for envelope_scaler: ramps through every ADSR phase and
// checks levels, states and scaled output against hand-derived values.
module tb_envelope_scaler;
    logic clk;
    logic rst_n;
    int   vecs;
    int   errs;

    envelope_scaler_if ifc ();

    envelope_scaler dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_open();
        ifc.gate_open = 1'b1;
        tick();
        ifc.gate_open = 1'b0;
    endtask

    task automatic pulse_close();
        ifc.gate_close = 1'b1;
        tick();
        ifc.gate_close = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string name);
        int n;
        n = 0;
        while (ifc.state !== st && n < budget) begin
            tick();
            n++;
        end
        vecs++;
        if (ifc.state !== st) begin
            errs++;
            $display("FAIL %s: timeout, state=%0d required=%0d", name, ifc.state, st);
        end
    endtask

    task automatic test_reset();
        vecs++;
        if (ifc.state !== 3'd0 || ifc.level !== 8'h00 || ifc.out !== 8'h00 || ifc.active !== 1'b0) begin
            errs++;
            $display("FAIL reset: state=%0d level=%h out=%h active=%b required 0/00/00/0",
                     ifc.state, ifc.level, ifc.out, ifc.active);
        end
    endtask

    task automatic test_attack();
        ifc.attack   = 8'hFF;
        ifc.decay    = 8'h7F;
        ifc.sustain  = 8'h80;
        ifc.release_rate = 8'hFF;
        ifc.waveform = 8'hFF;
        pulse_open();
        vecs++;
        if (ifc.state !== 3'd1 || ifc.level !== 8'h00 || ifc.active !== 1'b1) begin
            errs++;
            $display("FAIL attack_enter: state=%0d level=%h active=%b required 1/00/1",
                     ifc.state, ifc.level, ifc.active);
        end
        for (int i = 1; i <= 255; i++) begin
            tick();
            vecs++;
            if (ifc.state !== 3'd1 || ifc.level !== 8'(i) || ifc.out !== 8'((255 * (i - 1)) >> 8)) begin
                errs++;
                $display("FAIL attack_ramp[%0d]: state=%0d level=%h out=%h required 1/%h/%h",
                         i, ifc.state, ifc.level, ifc.out, 8'(i), 8'((255 * (i - 1)) >> 8));
            end
        end
        tick();
        vecs++;
        if (ifc.state !== 3'd2 || ifc.level !== 8'hFF || ifc.out !== 8'hFE) begin
            errs++;
            $display("FAIL attack_peak: state=%0d level=%h out=%h required 2/ff/fe",
                     ifc.state, ifc.level, ifc.out);
        end
    endtask

    task automatic test_decay();
        int a;
        for (int k = 1; k <= 255; k++) begin
            tick();
            a = 65535 - k * 128;
            vecs++;
            if (ifc.state !== 3'd2 || ifc.level !== 8'(a >> 8)) begin
                errs++;
                $display("FAIL decay_ramp[%0d]: state=%0d level=%h required 2/%h",
                         k, ifc.state, ifc.level, 8'(a >> 8));
            end
        end
        tick();
        vecs++;
        if (ifc.state !== 3'd3 || ifc.level !== 8'h80) begin
            errs++;
            $display("FAIL decay_to_sustain: state=%0d level=%h required 3/80", ifc.state, ifc.level);
        end
        ifc.sustain = 8'h20;
        tick();
        vecs++;
        if (ifc.state !== 3'd3 || ifc.level !== 8'h20) begin
            errs++;
            $display("FAIL sustain_track: state=%0d level=%h required 3/20", ifc.state, ifc.level);
        end
        ifc.waveform = 8'h80;
        tick();
        vecs++;
        if (ifc.out !== 8'h10) begin
            errs++;
            $display("FAIL sustain_out: out=%h required 10", ifc.out);
        end
    endtask

    task automatic test_release();
        pulse_close();
        vecs++;
        if (ifc.state !== 3'd4 || ifc.level !== 8'h20) begin
            errs++;
            $display("FAIL release_enter: state=%0d level=%h required 4/20", ifc.state, ifc.level);
        end
        for (int k = 1; k <= 31; k++) begin
            tick();
            vecs++;
            if (ifc.state !== 3'd4 || ifc.level !== 8'(32 - k) || ifc.active !== 1'b1) begin
                errs++;
                $display("FAIL release_ramp[%0d]: state=%0d level=%h active=%b required 4/%h/1",
                         k, ifc.state, ifc.level, ifc.active, 8'(32 - k));
            end
        end
        tick();
        vecs++;
        if (ifc.state !== 3'd0 || ifc.level !== 8'h00 || ifc.active !== 1'b0) begin
            errs++;
            $display("FAIL release_end: state=%0d level=%h active=%b required 0/00/0",
                     ifc.state, ifc.level, ifc.active);
        end
    endtask

    task automatic test_retrigger();
        ifc.sustain = 8'h10;
        ifc.decay   = 8'hFF;
        pulse_open();
        wait_state(3'd3, 600, "retrig_reach_sustain");
        pulse_close();
        vecs++;
        if (ifc.state !== 3'd4 || ifc.level !== 8'h10) begin
            errs++;
            $display("FAIL retrig_release: state=%0d level=%h required 4/10", ifc.state, ifc.level);
        end
        pulse_open();
        vecs++;
        if (ifc.state !== 3'd1 || ifc.level !== 8'h10) begin
            errs++;
            $display("FAIL retrig_legato: state=%0d level=%h required 1/10", ifc.state, ifc.level);
        end
        tick();
        vecs++;
        if (ifc.state !== 3'd1 || ifc.level !== 8'h11) begin
            errs++;
            $display("FAIL retrig_step: state=%0d level=%h required 1/11", ifc.state, ifc.level);
        end
        wait_state(3'd3, 600, "retrig_sustain_again");
        ifc.gate_open  = 1'b1;
        ifc.gate_close = 1'b1;
        tick();
        ifc.gate_open  = 1'b0;
        ifc.gate_close = 1'b0;
        vecs++;
        if (ifc.state !== 3'd1 || ifc.level !== 8'h10) begin
            errs++;
            $display("FAIL both_gates: state=%0d level=%h required 1/10", ifc.state, ifc.level);
        end
    endtask

    task automatic test_sustain_full();
        ifc.sustain = 8'hFF;
        ifc.decay   = 8'hFF;
        wait_state(3'd2, 600, "full_reach_decay");
        vecs++;
        if (ifc.level !== 8'hFF) begin
            errs++;
            $display("FAIL full_decay_level: level=%h required ff", ifc.level);
        end
        tick();
        vecs++;
        if (ifc.state !== 3'd3 || ifc.level !== 8'hFF) begin
            errs++;
            $display("FAIL full_sustain: state=%0d level=%h required 3/ff", ifc.state, ifc.level);
        end
    endtask

    task automatic test_gate_close_idle();
        pulse_close();
        wait_state(3'd0, 600, "close_reach_idle");
        pulse_close();
        tick();
        vecs++;
        if (ifc.state !== 3'd0 || ifc.level !== 8'h00 || ifc.active !== 1'b0) begin
            errs++;
            $display("FAIL close_in_idle: state=%0d level=%h active=%b required 0/00/0",
                     ifc.state, ifc.level, ifc.active);
        end
    endtask

    task automatic test_reset_mid();
        ifc.attack   = 8'hFF;
        ifc.waveform = 8'hFF;
        pulse_open();
        for (int i = 0; i < 64; i++) tick();
        vecs++;
        if (ifc.state !== 3'd1 || ifc.level !== 8'h40) begin
            errs++;
            $display("FAIL mid_attack_level: state=%0d level=%h required 1/40", ifc.state, ifc.level);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vecs++;
        if (ifc.state !== 3'd0 || ifc.level !== 8'h00 || ifc.out !== 8'h00 || ifc.active !== 1'b0) begin
            errs++;
            $display("FAIL async_reset: state=%0d level=%h out=%h active=%b required 0/00/00/0",
                     ifc.state, ifc.level, ifc.out, ifc.active);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        vecs++;
        if (ifc.state !== 3'd0 || ifc.level !== 8'h00 || ifc.out !== 8'h00 || ifc.active !== 1'b0) begin
            errs++;
            $display("FAIL after_reset: state=%0d level=%h out=%h active=%b required 0/00/00/0",
                     ifc.state, ifc.level, ifc.out, ifc.active);
        end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        rst_n = 1'b0;
        ifc.gate_open    = 1'b0;
        ifc.gate_close   = 1'b0;
        ifc.attack       = 8'h00;
        ifc.decay        = 8'h00;
        ifc.sustain      = 8'h00;
        ifc.release_rate = 8'h00;
        ifc.waveform     = 8'h00;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_attack();
        test_decay();
        test_release();
        test_retrigger();
        test_sustain_full();
        test_gate_close_idle();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
